edge_detect5: RTL

Consumes the 25-tap window produced by the 5-line buffer and computes a 5x5 separable Sobel gradient magnitude for the window centre. The result is thresholded into an edge flag. It sits directly downstream of the line buffer, which supplies `iGrid`, and upstream of the VGA colour mux, which uses `oEdge` to substitute the line colour. It is a 3-stage pipeline, advanced only on the same `clken` strobe that shifts the buffer, with row/column counters to suppress border windows.

---
 rtl/edge_detect5.sv | 134 +++++++++++++
 1 files changed

// File: rtl/edge_detect5.sv
// 5x5 separable Sobel gradient magnitude with edge threshold.
// Three-stage pipeline advanced by the line-buffer pixel strobe.
module edge_detect5 #(
   parameter int p_bit_width_in = 8,
   parameter int p_width        = 640,
   parameter int p_height       = 480
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clken,
   input  logic                        iSof,
   input  logic [p_bit_width_in*25-1:0] iGrid,
   input  logic [14:0]                 iThreshold,
   output logic                        oValid,
   output logic                        oEdge,
   output logic [7:0]                  oMag
);

   localparam int W  = p_bit_width_in;
   localparam int CW = $clog2(p_width);
   localparam int RW = $clog2(p_height);

   logic [CW-1:0] col_q, col_d, pos_col;
   logic [RW-1:0] row_q, row_d, pos_row;
   logic          win_valid;

   logic signed [15:0] tap  [5][5];
   logic signed [15:0] hs_d [5];
   logic signed [15:0] hs_q [5];
   logic signed [15:0] hd_d [5];
   logic signed [15:0] hd_q [5];
   logic               v1_q;

   logic signed [15:0] gx_d, gx_q;
   logic signed [15:0] gy_d, gy_q;
   logic               v2_q;

   logic [15:0] ax, ay;
   logic [14:0] mag;
   logic        valid_d, valid_q;
   logic        edge_d, edge_q;
   logic [7:0]  mag_d, mag_q;

   // Position of the newest tap; frame start overrides the counters.
   always_comb begin
      pos_col = iSof ? '0 : col_q;
      pos_row = iSof ? '0 : row_q;
      col_d   = pos_col + CW'(1);
      row_d   = pos_row;
      if (pos_col == CW'(p_width - 1)) begin
         col_d = '0;
         if (pos_row == RW'(p_height - 1))
            row_d = '0;
         else
            row_d = pos_row + RW'(1);
      end
      win_valid = (pos_row >= RW'(4)) && (pos_col >= CW'(4));
   end

   always_comb begin
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            tap[r][c] = 16'(iGrid[(24 - (5*r + c))*W +: W]);
         end
      end
      for (int r = 0; r < 5; r++) begin
         hs_d[r] = tap[r][0] + tap[r][4]
                 + 16'sd4 * (tap[r][1] + tap[r][3])
                 + 16'sd6 * tap[r][2];
         hd_d[r] = tap[r][4] - tap[r][0]
                 + 16'sd2 * (tap[r][3] - tap[r][1]);
      end
   end

   always_comb begin
      gx_d = hd_q[0] + hd_q[4]
           + 16'sd4 * (hd_q[1] + hd_q[3])
           + 16'sd6 * hd_q[2];
      gy_d = hs_q[4] - hs_q[0]
           + 16'sd2 * (hs_q[3] - hs_q[1]);
   end

   always_comb begin
      ax      = gx_q[15] ? 16'(-gx_q) : 16'(gx_q);
      ay      = gy_q[15] ? 16'(-gy_q) : 16'(gy_q);
      mag     = 15'(ax + ay);
      valid_d = v2_q;
      edge_d  = v2_q && (mag > iThreshold);
      mag_d   = '0;
      if (v2_q) begin
         if (mag[14:4] > 11'd255)
            mag_d = 8'hff;
         else
            mag_d = mag[11:4];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q   <= '0;
         row_q   <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         gx_q    <= '0;
         gy_q    <= '0;
         valid_q <= 1'b0;
         edge_q  <= 1'b0;
         mag_q   <= '0;
         for (int r = 0; r < 5; r++) begin
            hs_q[r] <= '0;
            hd_q[r] <= '0;
         end
      end else if (clken) begin
         col_q   <= col_d;
         row_q   <= row_d;
         v1_q    <= win_valid;
         v2_q    <= v1_q;
         gx_q    <= gx_d;
         gy_q    <= gy_d;
         valid_q <= valid_d;
         edge_q  <= edge_d;
         mag_q   <= mag_d;
         for (int r = 0; r < 5; r++) begin
            hs_q[r] <= hs_d[r];
            hd_q[r] <= hd_d[r];
         end
      end
   end

   assign oValid = valid_q;
   assign oEdge  = edge_q;
   assign oMag   = mag_q;

endmodule
